nibble_stream_pack: RTL and testbench
=====================================

# nibble_stream_pack

Assembles a stream of ELEM_W-bit elements, arriving one per valid/ready beat, into packed words of NELEM elements. Element 0 of each word lands in the most-significant slice, so slicing a packed word into elements and streaming them through this block reproduces the word bit-for-bit. It sits on the receive side of element-serial links: element producers on one side, wide-word consumers on the other.

## Interface
- ELEM_W, 4, width of one element in bits
- NELEM, 5, elements per output word (>= 2)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  element valid
- in_data  input  ELEM_W  element value
- in_ready  output  1  block accepts element this cycle
- out_valid  output  1  packed word valid
- out_data  output  ELEM_W*NELEM  packed word, element 0 in [ELEM_W*NELEM-1 -: ELEM_W]
- out_ready  input  1  consumer accepts word this cycle
- in_last  input  1  (only with STREAM_PACK_EARLY_LAST_EN) accepted element closes the word
- out_len  output  $clog2(NELEM+1)  (only with STREAM_PACK_EARLY_LAST_EN) valid element count in out_data

## Operation
- State: accumulator acc (ELEM_W*(NELEM-1) bits), element counter cnt (0..NELEM-1), output register out_data/out_valid.
- Beat accepted when in_valid && in_ready.
- Non-final beat (cnt < NELEM-1): store in_data in acc slot cnt (slot 0 = MSB), cnt <= cnt+1. Independent of output state.
- Final beat (cnt == NELEM-1): out_data <= {acc, in_data}, out_valid <= 1, cnt <= 0, acc cleared.
- in_ready = (cnt != NELEM-1) || !out_valid || out_ready. Only the final element is ever stalled.
- Output handshake: word retired when out_valid && out_ready; out_valid drops next cycle unless a new final beat is accepted in the same cycle (then out_valid stays 1 with new data).
- out_data and out_len hold stable while out_valid && !out_ready.
- Dropping in_valid between beats is legal; partial words persist indefinitely.
- Reset mid-word: partial elements discarded, pending output word discarded.

## Timing
- Reset values: out_valid=0, out_data=0, cnt=0, acc=0, out_len=0; in_ready=1 after reset.
- Latency: out_valid rises the cycle after the final element is accepted.
- Throughput: one element per cycle sustained; with out_ready held 1, one word every NELEM cycles, no bubbles.
- in_ready depends combinationally on out_ready; out_valid/out_data are registered.
- rst has priority over every handshake in the same cycle.

## Configuration
- STREAM_PACK_EARLY_LAST_EN defined: in_last and out_len exist. An accepted beat with in_last=1 is treated as final regardless of cnt (in_ready uses the same stall rule for it); unfilled lower slots are zero; out_len = cnt+1 of that beat. A full word without in_last gives out_len=NELEM. in_last on element NELEM-1 is a normal full word.
- Not defined: ports absent; every word is exactly NELEM elements.

## Test plan
- Beats 1,2,3,4,5, out_ready=1 -> one cycle after beat 5, out_valid=1, out_data=20'h12345.
- Back-to-back 10 elements 0..9, out_ready=1 -> words 20'h01234 then 20'h56789, no in_ready drop.
- Word 20'hABCDE held with out_ready=0; next beats 1,2,3,4 accepted, 5th stalled (in_ready=0) -> out_data stays 20'hABCDE; on out_ready=1 the 5th is accepted same cycle, next cycle out_data=20'h12345, out_valid stays 1.
- Beats 7,7 then rst=1 for one cycle, then 1..5 -> single word 20'h12345, no residue of 7s.
- (EARLY_LAST_EN) beats A, B with in_last on B -> out_data=20'hAB000, out_len=2; next 5 beats form a full word with out_len=5.

Source files
------------

// File: rtl/nibble_stream_pack_if.sv
// nibble_stream_pack_if
//   Handshake bundle for nibble_stream_pack: the element input stream
//   (in_valid/in_data/in_ready) and the packed-word output stream
//   (out_valid/out_data/out_ready).
//   Optional STREAM_PACK_EARLY_LAST_EN adds in_last and out_len.
//   Modports:
//     slave  - the packer itself (consumes elements, produces words)
//     master - the environment (produces elements, consumes words)
interface nibble_stream_pack_if #(
  parameter int unsigned ELEM_W = 4,
  parameter int unsigned NELEM  = 5
);
  logic                     in_valid;
  logic [ELEM_W-1:0]        in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [ELEM_W*NELEM-1:0]  out_data;
  logic                     out_ready;
`ifdef STREAM_PACK_EARLY_LAST_EN
  logic                         in_last;
  logic [$clog2(NELEM+1)-1:0]   out_len;
`endif

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
`ifdef STREAM_PACK_EARLY_LAST_EN
    ,
    input  in_last,
    output out_len
`endif
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
`ifdef STREAM_PACK_EARLY_LAST_EN
    ,
    output in_last,
    input  out_len
`endif
  );
endinterface

// File: rtl/nibble_stream_pack.sv
// nibble_stream_pack
//   Packs a stream of ELEM_W-bit elements into words of NELEM elements.
//   Element 0 of a word lands in the most-significant slice.
//   Optional feature macro: STREAM_PACK_EARLY_LAST_EN (in_last closes a
//   word early, unfilled slots are zero, out_len reports element count).
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset (priority over handshakes)
//     s   - nibble_stream_pack_if.slave: element input / word output
module nibble_stream_pack #(
  parameter int unsigned ELEM_W = 4,
  parameter int unsigned NELEM  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_stream_pack_if.slave   s
);
  localparam int unsigned CNT_W  = $clog2(NELEM);
  localparam int unsigned WORD_W = ELEM_W * NELEM;
  localparam int unsigned ACC_W  = ELEM_W * (NELEM - 1);

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] out_data_r;
  logic              out_valid_r;
  logic [WORD_W-1:0] word;
  logic              at_last_slot;
  logic              final_beat;
  logic              in_ready_c;
  logic              accept;

`ifdef STREAM_PACK_EARLY_LAST_EN
  localparam int unsigned LEN_W = $clog2(NELEM + 1);
  logic [LEN_W-1:0] out_len_r;
`endif

  assign at_last_slot = (cnt == CNT_W'(NELEM - 1));

`ifdef STREAM_PACK_EARLY_LAST_EN
  // An early-last beat closes the word, so it stalls exactly like a full one.
  assign final_beat = at_last_slot || s.in_last;
`else
  assign final_beat = at_last_slot;
`endif

  // Only a word-closing element can be stalled; partial elements always go in.
  assign in_ready_c = !final_beat || !out_valid_r || s.out_ready;
  assign accept     = s.in_valid && in_ready_c;

  // Current partial word with the incoming element dropped into slot cnt.
  // Slots above cnt hold earlier elements, slots below are still zero, so
  // this serves both as the next accumulator and as the closed word.
  always_comb begin
    word = {acc, {ELEM_W{1'b0}}};
    for (int unsigned i = 0; i < NELEM; i++) begin
      if (cnt == CNT_W'(i)) begin
        word[ELEM_W*(NELEM-i)-1 -: ELEM_W] = s.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
`ifdef STREAM_PACK_EARLY_LAST_EN
      out_len_r   <= '0;
`endif
    end else begin
      if (out_valid_r && s.out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (accept) begin
        if (final_beat) begin
          // Overrides the retire above when a new word closes in the same cycle.
          out_data_r  <= word;
          out_valid_r <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
`ifdef STREAM_PACK_EARLY_LAST_EN
          out_len_r   <= LEN_W'(cnt) + LEN_W'(1);
`endif
        end else begin
          acc <= word[WORD_W-1:ELEM_W];
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_r;
  assign s.out_data  = out_data_r;
`ifdef STREAM_PACK_EARLY_LAST_EN
  assign s.out_len   = out_len_r;
`endif

endmodule

// File: tb/tb_nibble_stream_pack.sv
// tb_nibble_stream_pack
//   Directed table-driven bench for nibble_stream_pack (ELEM_W=4, NELEM=5).
//   Each row: inputs applied for one cycle; in_ready checked before the edge,
//   out_valid/out_data checked 1ns after the edge.
module tb_nibble_stream_pack;
  localparam int unsigned ELEM_W = 4;
  localparam int unsigned NELEM  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_stream_pack_if #(.ELEM_W(ELEM_W), .NELEM(NELEM)) bus ();

  nibble_stream_pack #(.ELEM_W(ELEM_W), .NELEM(NELEM)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  d;
    logic        ordy;
    logic        ex_rdy;
    logic        ex_ov;
    logic [19:0] ex_od;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void add(input logic r, input logic iv, input logic [3:0] d,
                              input logic ordy, input logic ex_rdy,
                              input logic ex_ov, input logic [19:0] ex_od);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ex_rdy = ex_rdy; v.ex_ov = ex_ov; v.ex_od = ex_od;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [3:0] d,
                       input logic lst, input logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef STREAM_PACK_EARLY_LAST_EN
    bus.in_last   = lst;
`else
    if (lst) $display("note: in_last ignored in this build");
`endif
    #1;
  endtask

  initial begin
    // reset state
    add(1, 0, 4'h0, 0, 1, 0, 20'h00000);
    // beats 1..5, out_ready=1
    add(0, 1, 4'h1, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h2, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h3, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h4, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h5, 1, 1, 1, 20'h12345);
    add(0, 0, 4'h0, 1, 1, 0, 20'h12345);
    // back-to-back 0..9, no in_ready drop
    add(0, 1, 4'h0, 1, 1, 0, 20'h12345);
    add(0, 1, 4'h1, 1, 1, 0, 20'h12345);
    add(0, 1, 4'h2, 1, 1, 0, 20'h12345);
    add(0, 1, 4'h3, 1, 1, 0, 20'h12345);
    add(0, 1, 4'h4, 1, 1, 1, 20'h01234);
    add(0, 1, 4'h5, 1, 1, 0, 20'h01234);
    add(0, 1, 4'h6, 1, 1, 0, 20'h01234);
    add(0, 1, 4'h7, 1, 1, 0, 20'h01234);
    add(0, 1, 4'h8, 1, 1, 0, 20'h01234);
    add(0, 1, 4'h9, 1, 1, 1, 20'h56789);
    add(0, 0, 4'h0, 1, 1, 0, 20'h56789);
    // ABCDE held, next word stalls on its final element
    add(0, 1, 4'hA, 0, 1, 0, 20'h56789);
    add(0, 1, 4'hB, 0, 1, 0, 20'h56789);
    add(0, 1, 4'hC, 0, 1, 0, 20'h56789);
    add(0, 1, 4'hD, 0, 1, 0, 20'h56789);
    add(0, 1, 4'hE, 0, 1, 1, 20'hABCDE);
    add(0, 1, 4'h1, 0, 1, 1, 20'hABCDE);
    add(0, 1, 4'h2, 0, 1, 1, 20'hABCDE);
    add(0, 1, 4'h3, 0, 1, 1, 20'hABCDE);
    add(0, 1, 4'h4, 0, 1, 1, 20'hABCDE);
    add(0, 1, 4'h5, 0, 0, 1, 20'hABCDE);
    add(0, 1, 4'h5, 0, 0, 1, 20'hABCDE);
    add(0, 1, 4'h5, 1, 1, 1, 20'h12345);
    add(0, 0, 4'h0, 1, 1, 0, 20'h12345);
    // 7,7 then reset (with a competing beat), then 1..5
    add(0, 1, 4'h7, 1, 1, 0, 20'h12345);
    add(0, 1, 4'h7, 1, 1, 0, 20'h12345);
    add(1, 1, 4'h9, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h1, 0, 1, 0, 20'h00000);
    add(0, 0, 4'hF, 0, 1, 0, 20'h00000);
    add(0, 1, 4'h2, 0, 1, 0, 20'h00000);
    add(0, 1, 4'h3, 0, 1, 0, 20'h00000);
    add(0, 1, 4'h4, 0, 1, 0, 20'h00000);
    add(0, 1, 4'h5, 0, 1, 1, 20'h12345);
    // reset discards a pending word
    add(1, 1, 4'h6, 0, 1, 0, 20'h00000);
    add(0, 1, 4'h6, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h7, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h8, 1, 1, 0, 20'h00000);
    add(0, 1, 4'h9, 1, 1, 0, 20'h00000);
    add(0, 1, 4'hA, 1, 1, 1, 20'h6789A);
    add(0, 0, 4'h0, 1, 1, 0, 20'h6789A);

    drive(1, 0, 4'h0, 0, 0);
    @(posedge clk); @(posedge clk); #1;

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].iv, vecs[k].d, 0, vecs[k].ordy);
      chk($sformatf("row%0d in_ready", k), {31'd0, bus.in_ready}, {31'd0, vecs[k].ex_rdy});
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", k), {31'd0, bus.out_valid}, {31'd0, vecs[k].ex_ov});
      chk($sformatf("row%0d out_data", k), {12'd0, bus.out_data}, {12'd0, vecs[k].ex_od});
    end

`ifdef STREAM_PACK_EARLY_LAST_EN
    // A, B(last) -> AB000 len 2, then a full word 1..5 -> len 5,
    // then in_last on the fifth element -> ordinary full word
    drive(0, 1, 4'hA, 0, 1);
    @(posedge clk); #1;
    drive(0, 1, 4'hB, 1, 1);
    chk("early in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("early out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("early out_data", {12'd0, bus.out_data}, 32'h000AB000);
    chk("early out_len", {29'd0, bus.out_len}, 32'd2);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 4'(i), 0, 1);
      @(posedge clk); #1;
    end
    chk("full out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("full out_data", {12'd0, bus.out_data}, 32'h00012345);
    chk("full out_len", {29'd0, bus.out_len}, 32'd5);
    for (int i = 6; i <= 10; i++) begin
      drive(0, 1, 4'(i), (i == 10) ? 1'b1 : 1'b0, 1);
      @(posedge clk); #1;
    end
    chk("last5 out_data", {12'd0, bus.out_data}, 32'h0006789A);
    chk("last5 out_len", {29'd0, bus.out_len}, 32'd5);
    // early last stalled behind a held word
    drive(0, 1, 4'hC, 1, 0);
    chk("early stall in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("early stall out_data", {12'd0, bus.out_data}, 32'h0006789A);
    drive(0, 1, 4'hC, 1, 1);
    @(posedge clk); #1;
    chk("early one out_data", {12'd0, bus.out_data}, 32'h000C0000);
    chk("early one out_len", {29'd0, bus.out_len}, 32'd1);
`endif

    drive(0, 0, 4'h0, 0, 1);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
